// File: rtl/seg7_result_display.sv
// Four-digit multiplexed hex display driver with frame-aligned commit of loaded values.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_result_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  anodes,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        busy
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [DIV_W-1:0] div;
  logic [1:0]       dig;
  logic [15:0]      disp;
  logic [15:0]      pend;
  logic             pend_v;
  logic             wrap;
  logic             frame_end;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             blank;
  logic [3:0]       an_logic;
  logic [6:0]       seg_logic;

  assign wrap      = (div == DIV_LAST);
  assign frame_end = wrap && (dig == 2'd3);
  assign busy      = pend_v;

  // A load landing on the frame boundary bypasses the pending buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      dig    <= 2'd0;
      disp   <= 16'h0000;
      pend   <= 16'h0000;
      pend_v <= 1'b0;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      if (wrap) begin
        dig <= dig + 2'd1;
      end
      if (frame_end) begin
        if (load) begin
          disp <= value;
        end else if (pend_v) begin
          disp <= pend;
        end
        pend_v <= 1'b0;
      end else if (load) begin
        pend   <= value;
        pend_v <= 1'b1;
      end
    end
  end

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    case (dig)
      2'd0: nibble = disp[3:0];
      2'd1: nibble = disp[7:4];
      2'd2: nibble = disp[11:8];
      default: nibble = disp[15:12];
    endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    case (dig)
      2'd1: blank = (disp[15:4] == 12'h000);
      2'd2: blank = (disp[15:8] == 8'h00);
      2'd3: blank = (disp[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
  end

  always_comb begin
    glyph = 7'b0000000;
    case (nibble)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
  end

  assign an_logic  = 4'b0001 << dig;
  assign seg_logic = blank ? 7'b0000000 : glyph;

  // Anodes and segments share one register so they always switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      anodes   <= AN_OFF;
      segments <= SEG_OFF;
      dp       <= DP_OFF;
    end else begin
      anodes   <= ACTIVE_LOW ? ~an_logic : an_logic;
      segments <= ACTIVE_LOW ? ~seg_logic : seg_logic;
      dp       <= DP_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_result_display.sv
// Self-checking bench for seg7_result_display: directed scenarios plus random loads/resets
// compared every cycle against a cycle-count based reference model.
module tb_seg7_result_display;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Reference model: n = clock edges since reset release.
  int          n = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic        m_pv = 1'b0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;

  logic [6:0] glyph [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                             7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  seg7_result_display #(.REFRESH_DIV(R), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .anodes(anodes), .segments(segments), .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, step the model at the edge, then check all outputs.
  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v);
    int d;
    logic [3:0] nib;
    logic blank;
    rst = r; load = l; value = v;
    @(posedge clk);
    if (r) begin
      n = 0; m_disp = 0; m_pend = 0; m_pv = 0;
      exp_an = 4'hF; exp_seg = 7'h7F;
    end else begin
      d = (n / R) % 4;
      nib = 4'((m_disp >> (4 * d)) & 16'hF);
      blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      blank = (d != 0) && ((m_disp >> (4 * d)) == 16'h0);
`endif
      exp_an  = ~(4'b0001 << d);
      exp_seg = blank ? 7'h7F : ~glyph[nib];
      n = n + 1;
      if (n % (4 * R) == 0) begin
        if (l) m_disp = v;
        else if (m_pv) m_disp = m_pend;
        m_pv = 1'b0;
      end else if (l) begin
        m_pend = v;
        m_pv = 1'b1;
      end
    end
    #1;
    checkOutput("anodes", {12'h0, anodes}, {12'h0, exp_an});
    checkOutput("segments", {9'h0, segments}, {9'h0, exp_seg});
    checkOutput("dp", {15'h0, dp}, 16'h0001);
    checkOutput("busy", {15'h0, busy}, {15'h0, m_pv});
  endtask

  initial begin
    // Reset held three cycles, then the power-up scan sequence.
    repeat (3) applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("rst_anodes_off", {12'h0, anodes}, 16'h000F);
    checkOutput("rst_segments_off", {9'h0, segments}, 16'h007F);
    checkOutput("rst_busy", {15'h0, busy}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("dig0_anode", {12'h0, anodes}, 16'h000E);
      checkOutput("dig0_zero", {9'h0, segments}, 16'h0040);
    end
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("dig1_anode", {12'h0, anodes}, 16'h000D);

    // Mid-frame load, committed at the next frame boundary.
    applyStimulus(1'b0, 1'b1, 16'h12AF);
    checkOutput("busy_after_load", {15'h0, busy}, 16'h0001);
    repeat (40) applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("busy_cleared", {15'h0, busy}, 16'h0000);

    // Two loads in one frame: only the last one may ever be shown.
    for (int i = 0; i < 64 && (n % (4 * R)) != 1; i++) applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'h1111);
    applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'h2222);
    repeat (36) applyStimulus(1'b0, 1'b0, 16'h0);

    // Load exactly on the frame-boundary edge takes the bypass path.
    for (int i = 0; i < 64 && (n % (4 * R)) != (4 * R - 1); i++) applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("bypass_align", 16'(n % (4 * R)), 16'(4 * R - 1));
    applyStimulus(1'b0, 1'b1, 16'hBEEF);
    checkOutput("bypass_busy", {15'h0, busy}, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("bypass_dig0_anode", {12'h0, anodes}, 16'h000E);
    checkOutput("bypass_dig0_F", {9'h0, segments}, 16'h000E);
    repeat (16) applyStimulus(1'b0, 1'b0, 16'h0);

    // Reset with a value pending discards it.
    applyStimulus(1'b0, 1'b1, 16'h5A5A);
    checkOutput("pending_before_rst", {15'h0, busy}, 16'h0001);
    applyStimulus(1'b1, 1'b1, 16'h7777);
    checkOutput("rst_clears_busy", {15'h0, busy}, 16'h0000);
    repeat (20) applyStimulus(1'b0, 1'b0, 16'h0);

    // Small value: exercises leading-zero handling in either build.
    applyStimulus(1'b0, 1'b1, 16'h0005);
    repeat (36) applyStimulus(1'b0, 1'b0, 16'h0);

    // Random loads with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic r, l;
      r = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 7) == 0);
      applyStimulus(r, l, 16'($urandom));
    end

    rst = 1'b0; load = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_result_display.md
# seg7_result_display

Four-digit, time-multiplexed seven-segment driver that consumes the processor's 16-bit `result` word and shows it as hexadecimal on the board display. It sits directly downstream of the processor core. It captures a new value on a load strobe and commits it only at a scan-frame boundary, so a digit never shows a mix of old and new values. All outputs are registered and glitch-free.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled; legal range 2..2^20.
- `ACTIVE_LOW`, default 1: 1 = anodes and segments driven low-true; 0 = high-true.
- `clk`  in  1  system clock; the single clock for the block.
- `rst`  in  1  reset; synchronous, active-high.
- `value`  in  16  word to display; digit 3 = value[15:12] … digit 0 = value[3:0].
- `load`  in  1  single-cycle strobe; samples `value` into the pending buffer.
- `anodes`  out  4  digit enables, one-hot in logical sense; bit n = digit n.
- `segments`  out  7  segment drive, bit order {g,f,e,d,c,b,a}.
- `dp`  out  1  decimal point; always logically off.
- `busy`  out  1  high while a loaded value is pending and not yet committed.

## Operation
- **Storage.**
  - Pending buffer `pend[15:0]` plus flag `pend_v`.
  - Display register `disp[15:0]`.
  - Divider `div` counts 0..REFRESH_DIV-1.
  - Digit index `dig[1:0]`.
- **Load.** On `load`=1: `pend <= value`, `pend_v <= 1`. A later load before commit overwrites `pend`; last write wins.
- **Divider.** Increments every cycle and wraps to 0 at REFRESH_DIV-1. On wrap, `dig <= dig+1`, with 3→0 wrap-around.
- **Frame boundary.** Defined as the divider wrap while `dig`=3.
  - At a frame boundary with `pend_v`=1: `disp <= pend`, `pend_v <= 0`.
  - If `load`=1 in the same cycle: the incoming `value` is committed directly to `disp` (bypass) and `pend_v` ends at 0.
- **Decode.** Digit nibble `disp[4*dig+3:4*dig]` maps to the standard hex glyphs, {g..a} logical:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- **Output polarity.** Outputs are inverted when ACTIVE_LOW=1. Exactly one anode is logically on after reset release.
- **`busy`.** Equals `pend_v`.

## Timing
- **Reset** (`rst`=1 at a clock edge):
  - `div`=0, `dig`=0, `disp`=0, `pend`=0, `pend_v`=0, `busy`=0.
  - `anodes` = all logically off (4'b1111 when ACTIVE_LOW=1); `segments` all off (7'b1111111 when ACTIVE_LOW=1); `dp` off (1 when ACTIVE_LOW=1).
- **Reset mid-frame** discards any pending value; `disp` returns to 0.
- **Output register.** `anodes` and `segments` are registered from `dig` and `disp`, one cycle after those change.
  - First cycle after reset release: still all-off.
  - Second cycle: digit 0 on, showing "0".
- **Dwell.** Each digit is on for exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- **Load-to-display latency.** From `load` to the first digit-0 output carrying the new value:
  - At most 4·REFRESH_DIV + 1 cycles.
  - At least 2 cycles, when `load` coincides with the frame boundary.
- **`load` during `rst`** is ignored.
- **Anode/segment change.** Both change on the same edge, so no ghost digit is shown.

## Configuration
- **Macro:** `SEG7_LEADING_ZERO_BLANK_EN`.
- **Defined:** digits above the most significant nonzero nibble of `disp` are blanked (segments all off, anode still scanned). Digit 0 is never blanked, so 0x0000 shows "0" and 0x00A3 shows "  A3".
- **Undefined:** all four digits are always shown, e.g. 0x00A3 shows "00A3".
- **Timing:** identical in both builds. The blanking decision uses the same registered `disp` as the decode.

## Test plan
Unless noted, REFRESH_DIV=4, ACTIVE_LOW=1, macro undefined.

1. **Reset:** hold `rst` 3 cycles, then release → `anodes`=1111 and `segments`=1111111 for 1 cycle; then `anodes`=1110 and `segments`=1000000 ("0") for 4 cycles; then `anodes`=1101.
2. **Load and frame commit:** `load` with `value`=16'h12AF mid-frame → `busy`=1 until the frame boundary; the following frame shows digit0 F=0001110, digit1 A=0001000, digit2 2=0100100, digit3 1=1111001.
3. **Last write wins:** two loads (16'h1111, then 16'h2222) within one frame → only 2222 is ever displayed; 1111 never appears on any digit.
4. **Boundary bypass:** `load` of 16'hBEEF on the exact frame-boundary cycle → `busy` stays 0; the next digit 0 shows F.
5. **Reset mid-operation:** `rst` with `pend_v`=1 → `busy`=0, and the display restarts from "0000" with digit 0.
6. **Blanking build:** define the macro and load 16'h0005 → digits 3..1 show segments 1111111 while their anodes still scan; digit 0 shows 5=0010010.
